// File: rtl/pattern_gen_multi.sv
// HDMI test-pattern generator: delays timing by one clock and paints one of six
// patterns. Mode, bar thresholds, active size and box position change only at frame start.
module pattern_gen_multi #(
  parameter int DW          = 8,
  parameter int AUTO_FRAMES = 60,
  parameter int BOX_SIZE    = 64,
  parameter int BOX_STEP    = 2,
  parameter int GRID_SHIFT  = 5
)(
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     hactive,
  input  logic [15:0]     vactive,
  input  logic            timing_hs,
  input  logic            timing_vs,
  input  logic            timing_de,
  input  logic [11:0]     timing_x,
  input  logic [11:0]     timing_y,
  input  logic [2:0]      mode_sel,
  input  logic            auto_en,
  input  logic [3*DW-1:0] solid_rgb,
  output logic            hs,
  output logic            vs,
  output logic            de,
  output logic [DW-1:0]   rgb_r,
  output logic [DW-1:0]   rgb_g,
  output logic [DW-1:0]   rgb_b,
  output logic [2:0]      cur_mode
);
  localparam int CW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [DW-1:0] FS = {DW{1'b1}};
  localparam logic [DW-1:0] ZE = {DW{1'b0}};

  logic            r_hs, r_vs, r_de, r_armed;
  logic [3*DW-1:0] r_pix;
  logic [2:0]      r_mode;
  logic [CW-1:0]   r_cnt;
  logic [7:1][15:0] r_thr;
  logic [15:0]     r_hact, r_vact, r_bx, r_by;
  logic            r_dx, r_dy;

  logic            w_fs;
  logic [15:0]     w_x, w_y, w_bw;
  logic [16:0]     w_bx_nxt, w_by_nxt;
  logic            w_in_box;
  logic [3*DW-1:0] w_pix;

  // r_armed blocks a spurious frame start when vs is already high out of reset
  assign w_fs = timing_vs & ~r_vs & r_armed;
  assign w_x  = {4'b0, timing_x};
  assign w_y  = {4'b0, timing_y};
  assign w_bw = {3'b0, hactive[15:3]};

  // returns {dir, pos} after one frame of bounce against lim
  function automatic logic [16:0] bounce(input logic [15:0] pos, input logic dir,
                                         input logic [15:0] lim);
    logic [16:0] p17;
    p17 = {1'b0, pos};
    if (dir) begin
      if (p17 + 17'(BOX_SIZE) + 17'(BOX_STEP) > {1'b0, lim}) return {1'b0, pos - 16'(BOX_STEP)};
      else                                                   return {1'b1, pos + 16'(BOX_STEP)};
    end else begin
      if (p17 < 17'(BOX_STEP)) return {1'b1, pos + 16'(BOX_STEP)};
      else                     return {1'b0, pos - 16'(BOX_STEP)};
    end
  endfunction

  assign w_bx_nxt = bounce(r_bx, r_dx, hactive);
  assign w_by_nxt = bounce(r_by, r_dy, vactive);

  assign w_in_box = ({1'b0, w_x} >= {1'b0, r_bx}) && ({1'b0, w_x} < {1'b0, r_bx} + 17'(BOX_SIZE)) &&
                    ({1'b0, w_y} >= {1'b0, r_by}) && ({1'b0, w_y} < {1'b0, r_by} + 17'(BOX_SIZE));

  always_comb begin
    w_pix = '0;
    case (r_mode)
      3'd0: w_pix = solid_rgb;
      3'd1: begin
        if      (w_x < r_thr[1]) w_pix = {FS, FS, FS};
        else if (w_x < r_thr[2]) w_pix = {FS, FS, ZE};
        else if (w_x < r_thr[3]) w_pix = {ZE, FS, FS};
        else if (w_x < r_thr[4]) w_pix = {ZE, FS, ZE};
        else if (w_x < r_thr[5]) w_pix = {FS, ZE, FS};
        else if (w_x < r_thr[6]) w_pix = {FS, ZE, ZE};
        else if (w_x < r_thr[7]) w_pix = {ZE, ZE, FS};
        else                     w_pix = {ZE, ZE, ZE};
      end
      3'd2: if (w_x[GRID_SHIFT-1:0] == '0 || w_y[GRID_SHIFT-1:0] == '0 ||
                w_x == r_hact - 16'd1 || w_y == r_vact - 16'd1)
              w_pix = {FS, FS, FS};
      3'd3: w_pix = {3{w_x[DW-1:0]}};
      3'd4: if (w_in_box) w_pix = {FS, ZE, ZE};
      3'd5: if (!(w_x[GRID_SHIFT] ^ w_y[GRID_SHIFT])) w_pix = {FS, FS, FS};
      default: w_pix = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs <= 1'b0; r_vs <= 1'b0; r_de <= 1'b0; r_armed <= 1'b0;
      r_pix <= '0; r_mode <= 3'd0; r_cnt <= '0; r_thr <= '0;
      r_hact <= '0; r_vact <= '0; r_bx <= '0; r_by <= '0;
      r_dx <= 1'b1; r_dy <= 1'b1;
    end else begin
      r_hs  <= timing_hs;
      r_vs  <= timing_vs;
      r_de  <= timing_de;
      r_pix <= timing_de ? w_pix : '0;
      if (!timing_vs) r_armed <= 1'b1;
      if (w_fs) begin
        // k*bar_w by shift-add; 7*8191 still fits 16 bits
        r_thr <= {(w_bw << 3) - w_bw, (w_bw << 2) + (w_bw << 1), (w_bw << 2) + w_bw,
                  w_bw << 2, (w_bw << 1) + w_bw, w_bw << 1, w_bw};
        r_hact <= hactive;
        r_vact <= vactive;
        {r_dx, r_bx} <= w_bx_nxt;
        {r_dy, r_by} <= w_by_nxt;
        if (!auto_en) begin
          r_mode <= mode_sel;
          r_cnt  <= '0;
        end else if (r_cnt == CW'(AUTO_FRAMES - 1)) begin
          r_cnt  <= '0;
          r_mode <= (r_mode >= 3'd5) ? 3'd0 : r_mode + 3'd1;
        end else begin
          r_cnt  <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign hs       = r_hs;
  assign vs       = r_vs;
  assign de       = r_de;
  assign rgb_r    = r_pix[3*DW-1:2*DW];
  assign rgb_g    = r_pix[2*DW-1:DW];
  assign rgb_b    = r_pix[DW-1:0];
  assign cur_mode = r_mode;
endmodule

// File: tb/tb_pattern_gen_multi.sv
// Directed bench for pattern_gen_multi: scoreboard of expected pixels from a
// small frame-level model, popped one clock after each drive.
module tb_pattern_gen_multi;
  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] hactive = 16'd1920, vactive = 16'd1080;
  logic        timing_hs = 1'b0, timing_vs = 1'b0, timing_de = 1'b0;
  logic [11:0] timing_x = '0, timing_y = '0;
  logic [2:0]  mode_sel = 3'd0;
  logic        auto_en = 1'b0;
  logic [23:0] solid_rgb = 24'h123456;
  logic        hs, vs, de;
  logic [7:0]  rgb_r, rgb_g, rgb_b;
  logic [2:0]  cur_mode;

  pattern_gen_multi #(.DW(8), .AUTO_FRAMES(2), .BOX_SIZE(64), .BOX_STEP(2), .GRID_SHIFT(5)) dut (
    .clk(clk), .rst(rst), .hactive(hactive), .vactive(vactive),
    .timing_hs(timing_hs), .timing_vs(timing_vs), .timing_de(timing_de),
    .timing_x(timing_x), .timing_y(timing_y), .mode_sel(mode_sel), .auto_en(auto_en),
    .solid_rgb(solid_rgb), .hs(hs), .vs(vs), .de(de),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b), .cur_mode(cur_mode));

  always #5 clk = ~clk;

  typedef struct { string tag; logic [26:0] v; } exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0;

  logic [23:0] BARS [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  int m_mode, m_cnt, m_hact, m_vact, m_bw, m_bx, m_by;
  bit m_dx, m_dy;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_hact = 0; m_vact = 0; m_bw = 0;
    m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
  endtask

  task automatic model_fs();
    m_hact = int'(hactive); m_vact = int'(vactive); m_bw = int'(hactive) / 8;
    if (m_dx) begin if (m_bx + 66 > int'(hactive)) begin m_dx = 0; m_bx -= 2; end else m_bx += 2; end
    else      begin if (m_bx < 2) begin m_dx = 1; m_bx += 2; end else m_bx -= 2; end
    if (m_dy) begin if (m_by + 66 > int'(vactive)) begin m_dy = 0; m_by -= 2; end else m_by += 2; end
    else      begin if (m_by < 2) begin m_dy = 1; m_by += 2; end else m_by -= 2; end
    if (!auto_en) begin m_mode = int'(mode_sel); m_cnt = 0; end
    else if (m_cnt == 1) begin m_cnt = 0; m_mode = (m_mode >= 5) ? 0 : m_mode + 1; end
    else m_cnt++;
  endtask

  function automatic logic [23:0] exp_pix(int x, int y);
    logic [7:0] g;
    int idx;
    g = x[7:0];
    case (m_mode)
      0: return solid_rgb;
      1: begin
        if (m_bw == 0) return 24'h0;
        idx = x / m_bw;
        return (idx > 7) ? 24'h0 : BARS[idx];
      end
      2: return (x % 32 == 0 || y % 32 == 0 || x == m_hact - 1 || y == m_vact - 1) ? 24'hFFFFFF : 24'h0;
      3: return {g, g, g};
      4: return (x >= m_bx && x < m_bx + 64 && y >= m_by && y < m_by + 64) ? 24'hFF0000 : 24'h0;
      5: return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'h0 : 24'hFFFFFF;
      default: return 24'h0;
    endcase
  endfunction

  task automatic drv(string tag, bit h, bit v, bit d, int x, int y);
    exp_t e;
    @(negedge clk);
    timing_hs = h; timing_vs = v; timing_de = d;
    timing_x = 12'(x); timing_y = 12'(y);
    e.tag = tag;
    e.v = {h, v, d, d ? exp_pix(x, y) : 24'h0};
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check(e.tag, 32'({hs, vs, de, rgb_r, rgb_g, rgb_b}), 32'(e.v));
  endtask

  task automatic fs();
    drv("fs_lo", 0, 0, 0, 0, 0);
    model_fs();
    drv("fs_hi", 1, 1, 0, 0, 0);
    drv("fs_hi2", 0, 1, 0, 0, 0);
    drv("fs_lo2", 0, 0, 0, 0, 0);
    check("cur_mode", 32'(cur_mode), 32'(m_mode));
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; #1;
    check("rst_async_out", 32'({hs, vs, de, rgb_r, rgb_g, rgb_b}), 32'h0);
    check("rst_async_mode", 32'(cur_mode), 32'h0);
    @(negedge clk); rst = 1'b0; model_reset();
  endtask

  initial begin
    int xs[$];
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 32'({hs, vs, de, rgb_r, rgb_g, rgb_b}), 32'h0);
    check("reset_mode", 32'(cur_mode), 32'h0);
    @(negedge clk); rst = 1'b0;

    // latency / de width in default solid mode
    drv("lat_pre", 1, 0, 0, 0, 0);
    drv("lat_pre", 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drv("lat_de", 0, 0, 1, i, 0);
    drv("lat_post", 0, 0, 0, 10, 0);
    drv("lat_post", 0, 0, 0, 11, 0);

    // reset mid-line
    drv("mid", 0, 0, 1, 20, 0);
    do_reset();
    drv("after_rst", 0, 0, 1, 21, 0);

    // vs high across reset release: no frame start
    @(negedge clk); rst = 1'b1; timing_vs = 1'b1; mode_sel = 3'd3;
    @(negedge clk); rst = 1'b0; model_reset();
    repeat (3) drv("vs_held", 0, 1, 0, 0, 0);
    check("no_fs_held", 32'(cur_mode), 32'(m_mode));

    // colour bars
    hactive = 16'd1920; vactive = 16'd1080; mode_sel = 3'd1;
    fs();
    xs = '{0, 239, 240, 479, 480, 1679, 1680, 1800, 1919};
    foreach (xs[i]) drv("bars1920", 0, 0, 1, xs[i], 10);
    hactive = 16'd100;
    fs();
    xs = '{11, 12, 83, 84, 95, 96, 97, 98, 99};
    foreach (xs[i]) drv("bars100", 0, 0, 1, xs[i], 10);

    // mid-frame mode change waits for next frame
    hactive = 16'd1920;
    fs();
    drv("latch_pre", 0, 0, 1, 300, 499);
    mode_sel = 3'd3;
    drv("latch_mid", 0, 0, 1, 300, 500);
    drv("latch_mid", 0, 0, 1, 1700, 501);
    fs();
    drv("ramp", 0, 0, 1, 0, 0);
    drv("ramp", 0, 0, 1, 300, 0);
    drv("ramp", 0, 0, 1, 1919, 0);

    // grid and checkerboard
    mode_sel = 3'd2;
    fs();
    drv("grid", 0, 0, 1, 0, 5);    drv("grid", 0, 0, 1, 5, 5);
    drv("grid", 0, 0, 1, 32, 7);   drv("grid", 0, 0, 1, 1919, 7);
    drv("grid", 0, 0, 1, 7, 1079); drv("grid", 0, 0, 1, 33, 33);
    drv("grid", 0, 0, 1, 40, 64);
    mode_sel = 3'd5;
    fs();
    drv("chk", 0, 0, 1, 0, 0);  drv("chk", 0, 0, 1, 32, 0);
    drv("chk", 0, 0, 1, 32, 32); drv("chk", 0, 0, 1, 70, 31);
    mode_sel = 3'd7;
    fs();
    drv("mode7", 0, 0, 1, 0, 0);

    // auto-cycle from mode 0
    do_reset();
    auto_en = 1'b1; mode_sel = 3'd2;
    for (int i = 0; i < 14; i++) begin
      fs();
      drv("auto_px", 0, 0, 1, 40, 40);
    end
    auto_en = 1'b0;
    fs();
    mode_sel = 3'd6;
    fs();
    auto_en = 1'b1;
    fs();
    fs();
    check("mode6_wrap", 32'(cur_mode), 32'h0);
    auto_en = 1'b0;

    // box bounce in an 80x80 field
    do_reset();
    hactive = 16'd80; vactive = 16'd80; mode_sel = 3'd4;
    for (int i = 0; i < 18; i++) begin
      fs();
      drv("box_in", 0, 0, 1, m_bx, m_by);
      drv("box_in", 0, 0, 1, m_bx + 63, m_by + 63);
      drv("box_out", 0, 0, 1, m_bx + 64, m_by);
      drv("box_out", 0, 0, 1, m_bx, m_by + 64);
      if (m_bx > 0) drv("box_out", 0, 0, 1, m_bx - 1, m_by);
      if (i == 7) drv("box16", 0, 0, 1, 16, 16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pattern_gen_multi.md
# pattern_gen_multi

Parametrised test-pattern generator for the HDMI output path. It sits between the video timing generator and the encoder, and delays hs/vs/de by one clock. In the same clock it produces one of six selectable patterns at configurable colour depth. Mode changes and animation take effect only at frame boundaries, so no frame is torn; an optional auto-cycle mode steps through the patterns.

## Interface
Parameters:
- DW, 8, bits per colour channel (4..10)
- AUTO_FRAMES, 60, frames per pattern in auto-cycle mode (≥1)
- BOX_SIZE, 64, moving-box edge length in pixels
- BOX_STEP, 2, box displacement per frame in pixels, per axis
- GRID_SHIFT, 5, grid/checker cell = 2^GRID_SHIFT pixels

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- hactive  in  16  active pixels per line
- vactive  in  16  active lines per frame
- timing_hs  in  1  horizontal sync from timing generator
- timing_vs  in  1  vertical sync, active-high
- timing_de  in  1  data enable
- timing_x  in  12  active pixel column
- timing_y  in  12  active line
- mode_sel  in  3  manual pattern select
- auto_en  in  1  1 = auto-cycle patterns 0..5
- solid_rgb  in  3*DW  mode-0 colour {r,g,b}
- hs, vs, de  out  1 each  timing inputs delayed one clk
- rgb_r, rgb_g, rgb_b  out  DW each  pixel colour
- cur_mode  out  3  pattern currently displayed

## Operation
- Frame start: a rising edge of timing_vs, detected against a registered copy of vs. All frame-level state updates only on the clock in which frame start is detected.
- Mode latch at frame start:
  - When auto_en=0, cur_mode ← mode_sel.
  - When auto_en=1, frame_cnt increments. When frame_cnt = AUTO_FRAMES−1, frame_cnt ← 0 and cur_mode advances 0→1→…→5→0.
  - If cur_mode is 6 or 7 when auto advance occurs, cur_mode ← 0.
  - frame_cnt is cleared whenever auto_en=0.
- Patterns (FS = all-ones DW, x/y zero-extended to 16 bits):
  - 0 solid: solid_rgb, sampled every pixel.
  - 1 colour bars: bar_w = hactive>>3. Thresholds k·bar_w (k=1..7) are registered at frame start from shift-adds, with no divider. Bars from left are white, yellow, cyan, green, magenta, red, blue, black. Any x ≥ 7·bar_w is black.
  - 2 grid: white where x or y low GRID_SHIFT bits = 0, or x = hactive−1, or y = vactive−1. Black elsewhere.
  - 3 gray ramp: r=g=b=x[DW-1:0], wrapping every 2^DW pixels.
  - 4 moving box: red FS where box_x ≤ x < box_x+BOX_SIZE and box_y ≤ y < box_y+BOX_SIZE. Black elsewhere.
  - 5 checkerboard: FS white when x[GRID_SHIFT]^y[GRID_SHIFT]=0, otherwise black.
  - 6, 7: black.
- Box motion updates at every frame start, in every mode:
  - Moving right (dx=1): if box_x+BOX_SIZE+BOX_STEP > hactive then dx←0 and box_x←box_x−BOX_STEP, else box_x←box_x+BOX_STEP.
  - Moving left (dx=0): if box_x < BOX_STEP then dx←1 and box_x←box_x+BOX_STEP, else box_x←box_x−BOX_STEP.
  - The y axis moves identically against vactive.
  - All comparisons are 17-bit unsigned so no wrap occurs.
- When timing_de=0 the registered rgb is 0 regardless of mode.

## Timing
- Latency is 1 clk: hs/vs/de/rgb at edge n+1 reflect inputs at edge n.
- cur_mode changes on the clock after the frame-start edge. The first pixel of the new frame already uses the new mode.
- Reset values: hs=vs=de=0, rgb=0, cur_mode=0, frame_cnt=0, box_x=box_y=0, dx=dy=1, bar thresholds 0, vs history 0.
- Reset mid-frame: outputs go to 0 immediately. After release, the first vs rising edge loads the mode and thresholds.
- If vs is already high when rst releases, no frame start is generated until vs falls and rises again.
- mode_sel/auto_en changes mid-frame have no effect until the next frame start.
- A change of hactive/vactive is honoured from the next frame start.

## Test plan
- Reset, including an assertion mid-line: all outputs 0 during reset. cur_mode=0 and box at (0,0) after release.
- Latency: mode 0, solid_rgb={8'h12,8'h34,8'h56}, de pulse of 10 clk:
  - de/rgb out are exactly 10 clk wide, delayed 1 clk.
  - rgb=0 outside de.
- Colour bars, hactive=1920:
  - x=239 → FFFFFF, x=240 → FFFF00, x=1679 → 0000FF, x=1680..1919 → 000000.
  - With hactive=100 (bar_w=12), x=96..99 → black.
- Mode latch: mode_sel 1→3 asserted at mid-frame line 500. Bars continue to frame end; first pixel after the next vs rise is gray ramp with r=x[7:0]; cur_mode=3.
- Auto-cycle, AUTO_FRAMES=2, auto_en=1, starting from cur_mode=0:
  - cur_mode steps 0,0,1,1,2,…, and 5 is followed by 0.
  - Deasserting auto_en restores mode_sel at the next frame start.
- Box bounce, hactive=80, BOX_SIZE=64, BOX_STEP=2:
  - box_x runs 2,4,…,16, then reverses to 14.
  - At box_x = 0 the next value is 2.
  - Pixel x=box_x is red and x=box_x+64 is black.
